// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer gating register-file and data-memory writes
//   Optional feature: define SEQ_PERF_CNT_EN to add perf_instr_o / perf_stall_o counters.
//   Ports:
//     clk, rst_n                 clock (rising edge), asynchronous active-low reset
//     start_i                    pulse: leave IDLE/HALT and begin fetching
//     imem_req_o/addr_o          fetch request / address (= pc), held until imem_valid_i
//     imem_valid_i/rdata_i       fetched instruction handshake
//     ir_o                       instruction register to the control unit, opcode = ir_o[31:26]
//     cu_rwe_i/cu_mwe_i          control unit write enables decoded from ir_o
//     dmem_req_o/we_o/ack_i      data memory request, write strobe, completion
//     rf_we_o                    register-file write enable, one cycle in WB only
//     busy_o/halted_o/state_o    status: IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5 HALT=6
//     perf_instr_o/perf_stall_o  (SEQ_PERF_CNT_EN) decoded instructions / handshake stall cycles
module instr_sequencer #(
    parameter int ADDR_W   = 16,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 4,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_valid_i,
    input  logic [31:0]       imem_rdata_i,
    output logic [31:0]       ir_o,
    input  logic              cu_rwe_i,
    input  logic              cu_mwe_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    input  logic              dmem_ack_i,
    output logic              rf_we_o,
    output logic              busy_o,
    output logic              halted_o,
    output logic [2:0]        state_o
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  perf_instr_o,
    output logic [CNT_W-1:0]  perf_stall_o
`endif
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6
    } state_t;

    localparam logic [5:0] OP_HALT = 6'b111111;
    localparam logic [5:0] OP_LOAD = 6'b010000;

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [31:0]       ir_q;
    logic              st_q;
    logic [5:0]        op;

    assign op = ir_q[31:26];

    // st_q latches cu_mwe_i on leaving EXEC so dmem_we_o stays constant for the whole MEM phase
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            ir_q    <= '0;
            st_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE, HALT: if (start_i) state_q <= FETCH;
                FETCH: if (imem_valid_i) begin
                    ir_q    <= imem_rdata_i;
                    pc_q    <= pc_q + ADDR_W'(PC_STEP);
                    state_q <= DECODE;
                end
                DECODE: state_q <= (op == OP_HALT) ? HALT : EXEC;
                EXEC: begin
                    st_q    <= cu_mwe_i;
                    state_q <= (cu_mwe_i || op == OP_LOAD) ? MEM : cu_rwe_i ? WB : FETCH;
                end
                MEM: if (dmem_ack_i) state_q <= st_q ? FETCH : WB;
                WB: state_q <= FETCH;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign imem_req_o  = state_q == FETCH;
    assign imem_addr_o = pc_q;
    assign ir_o        = ir_q;
    assign dmem_req_o  = state_q == MEM;
    assign dmem_we_o   = state_q == MEM && st_q;
    assign rf_we_o     = state_q == WB;
    assign busy_o      = state_q != IDLE && state_q != HALT;
    assign halted_o    = state_q == HALT;
    assign state_o     = state_q;

`ifdef SEQ_PERF_CNT_EN
    logic [CNT_W-1:0] perf_instr_q;
    logic [CNT_W-1:0] perf_stall_q;
    logic             stall;

    assign stall = (state_q == FETCH && !imem_valid_i) || (state_q == MEM && !dmem_ack_i);

    // both counters saturate at all-ones and naturally hold in IDLE/HALT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_instr_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (state_q == FETCH && imem_valid_i && !(&perf_instr_q)) perf_instr_q <= perf_instr_q + CNT_W'(1);
            if (stall && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + CNT_W'(1);
        end
    end

    assign perf_instr_o = perf_instr_q;
    assign perf_stall_o = perf_stall_q;
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed self-checking bench for instr_sequencer (ADDR_W=4 to exercise pc wrap)
module tb_instr_sequencer;
    localparam logic [31:0] ADD   = 32'h0400_0000;
    localparam logic [31:0] STORE = 32'h0800_0000;
    localparam logic [31:0] LOAD  = 32'h4000_0005;
    localparam logic [31:0] HLT   = 32'hFC00_0000;

    logic        clk = 1'b0;
    logic        rst_n, start, imem_valid, cu_rwe, cu_mwe, dmem_ack;
    logic [31:0] imem_rdata;
    logic        imem_req, dmem_req, dmem_we, rf_we, busy, halted;
    logic [3:0]  imem_addr;
    logic [31:0] ir;
    logic [2:0]  state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] perf_instr, perf_stall;
`endif
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_valid_i(imem_valid), .imem_rdata_i(imem_rdata), .ir_o(ir),
        .cu_rwe_i(cu_rwe), .cu_mwe_i(cu_mwe),
        .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_ack_i(dmem_ack),
        .rf_we_o(rf_we), .busy_o(busy), .halted_o(halted), .state_o(state)
`ifdef SEQ_PERF_CNT_EN
        , .perf_instr_o(perf_instr), .perf_stall_o(perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        cu_rwe = 1'b0; cu_mwe = 1'b0; dmem_ack = 1'b0;
        #3;
        chk("rst_state", 32'(state), 0);
        chk("rst_imem_req", 32'(imem_req), 0);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_ir", ir, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_outs", {28'd0, halted, rf_we, dmem_req, dmem_we}, 0);
        tick();
        rst_n = 1'b1;
        // start and imem_valid together in IDLE: only start acts
        start = 1'b1; imem_valid = 1'b1; imem_rdata = ADD;
        tick();
        start = 1'b0;
        chk("idle_start_state", 32'(state), 1);
        chk("idle_start_ir", ir, 0);
        chk("fetch_req", 32'(imem_req), 1);
        chk("fetch_addr0", 32'(imem_addr), 0);
        // ADD, zero-wait; start while busy must be ignored
        tick();
        imem_valid = 1'b0; cu_rwe = 1'b1; start = 1'b1;
        chk("add_decode", 32'(state), 2);
        chk("add_ir", ir, ADD);
        chk("add_pc", 32'(imem_addr), 4);
        chk("add_busy", 32'(busy), 1);
        tick();
        chk("add_exec", 32'(state), 3);
        chk("add_rfwe_exec", 32'(rf_we), 0);
        tick();
        start = 1'b0;
        chk("add_wb", 32'(state), 5);
        chk("add_rfwe", 32'(rf_we), 1);
        tick();
        cu_rwe = 1'b0;
        chk("add_back_fetch", 32'(state), 1);
        chk("add_rfwe_off", 32'(rf_we), 0);
        // store, ack on the 3rd MEM cycle; stray valid/ack during DECODE are ignored
        imem_valid = 1'b1; imem_rdata = STORE;
        tick();
        imem_rdata = 32'hFFFF_FFFF; dmem_ack = 1'b1; cu_mwe = 1'b1;
        chk("st_decode", 32'(state), 2);
        chk("st_pc", 32'(imem_addr), 8);
        tick();
        imem_valid = 1'b0; dmem_ack = 1'b0;
        chk("st_exec", 32'(state), 3);
        chk("st_ir_kept", ir, STORE);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("st_mem_state", 32'(state), 4);
            chk("st_mem_req_we", {30'd0, dmem_req, dmem_we}, 3);
            chk("st_mem_rfwe", 32'(rf_we), 0);
            if (i == 2) dmem_ack = 1'b1;
            tick();
        end
        dmem_ack = 1'b0; cu_mwe = 1'b0;
        chk("st_back_fetch", 32'(state), 1);
        chk("st_req_off", 32'(dmem_req), 0);
        chk("st_rfwe", 32'(rf_we), 0);
        // HALT at pc 8
        imem_valid = 1'b1; imem_rdata = HLT;
        tick();
        imem_valid = 1'b0;
        chk("h_decode", 32'(state), 2);
        tick();
        chk("h_state", 32'(state), 6);
        chk("h_halted", 32'(halted), 1);
        chk("h_busy", 32'(busy), 0);
        chk("h_pc", 32'(imem_addr), 12);
        tick();
        chk("h_hold", 32'(state), 6);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("resume_state", 32'(state), 1);
        chk("resume_pc", 32'(imem_addr), 12);
        // LOAD at pc 12, pc wraps to 0, ack in first MEM cycle
        imem_valid = 1'b1; imem_rdata = LOAD;
        tick();
        imem_valid = 1'b0; cu_rwe = 1'b1;
        chk("ld_decode", 32'(state), 2);
        chk("ld_pc_wrap", 32'(imem_addr), 0);
        tick();
        chk("ld_exec", 32'(state), 3);
        tick();
        chk("ld_mem", 32'(state), 4);
        chk("ld_req_we", {30'd0, dmem_req, dmem_we}, 2);
        chk("ld_rfwe_mem", 32'(rf_we), 0);
        dmem_ack = 1'b1;
        tick();
        dmem_ack = 1'b0;
        chk("ld_wb", 32'(state), 5);
        chk("ld_rfwe", 32'(rf_we), 1);
        chk("ld_req_off", 32'(dmem_req), 0);
        tick();
        cu_rwe = 1'b0;
        chk("ld_fetch", 32'(state), 1);
        chk("ld_rfwe_off", 32'(rf_we), 0);
        // store, then async reset in the middle of MEM
        imem_valid = 1'b1; imem_rdata = STORE;
        tick();
        imem_valid = 1'b0; cu_mwe = 1'b1;
        tick();
        tick();
        chk("rm_mem", 32'(state), 4);
        chk("rm_req", 32'(dmem_req), 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rm_req_drop", 32'(dmem_req), 0);
        chk("rm_state", 32'(state), 0);
        chk("rm_ir", ir, 0);
        chk("rm_pc", 32'(imem_addr), 0);
        cu_mwe = 1'b0;
        #2;
`ifdef SEQ_PERF_CNT_EN
        chk("perf_rst", perf_instr | perf_stall, 0);
        rst_n = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            tick();
            tick();
            imem_valid = 1'b1; imem_rdata = ADD;
            tick();
            imem_valid = 1'b0; cu_rwe = 1'b1;
            tick();
            tick();
            tick();
            cu_rwe = 1'b0;
        end
        chk("perf_instr", perf_instr, 2);
        chk("perf_stall", perf_stall, 4);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
